// File: rtl/multicycle_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_fsm_if
//  Brief    : Opcode/handshake inputs and datapath control strobes of the
//             multicycle control FSM, bundled with master/slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_fsm_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                cond_true;

    logic                memToReg;
    logic                memWrite;
    logic                memRead;
    logic                branch;
    logic                regDst;
    logic                regWrite;
    logic                jmp;
    logic                IorD;
    logic                IRWrite;
    logic                pcWrite;
    logic                MACsrcBsel;
    logic                link;
    logic                trap;
    logic [ALUOP_W-1:0]  ALUOp;
    logic [1:0]          ALUSrcAControl;
    logic [1:0]          ALUSrcBControl;
    logic [1:0]          pcSrc;
    logic [3:0]          state;

    // The controller is the master: it consumes opcode/handshake and drives strobes.
    modport master (
        input  opcode, mem_ready, cond_true,
        output memToReg, memWrite, memRead, branch, regDst, regWrite, jmp,
               IorD, IRWrite, pcWrite, MACsrcBsel, link, trap,
               ALUOp, ALUSrcAControl, ALUSrcBControl, pcSrc, state
    );

    modport slave (
        output opcode, mem_ready, cond_true,
        input  memToReg, memWrite, memRead, branch, regDst, regWrite, jmp,
               IorD, IRWrite, pcWrite, MACsrcBsel, link, trap,
               ALUOp, ALUSrcAControl, ALUSrcBControl, pcSrc, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_fsm
//  Brief    : Multicycle processor control FSM with memory-wait timeout,
//             branch/JAL support and illegal-opcode trap.
//             Optional MAC instruction enabled by macro MULTICYCLE_MAC_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
    parameter int OPCODE_W     = 6,
    parameter int ALUOP_W      = 4,
    parameter int MAX_MEM_WAIT = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    multicycle_ctrl_fsm_if.master  bus
);

    localparam int CNT_W = (MAX_MEM_WAIT < 1) ? 1 : $clog2(MAX_MEM_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_MEM_WAIT);

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(13);
    localparam logic [OPCODE_W-1:0] OP_BGT   = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_BGE   = OPCODE_W'(17);
    localparam logic [OPCODE_W-1:0] OP_BLT   = OPCODE_W'(18);
    localparam logic [OPCODE_W-1:0] OP_BLE   = OPCODE_W'(19);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(35);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(43);
`ifdef MULTICYCLE_MAC_EN
    localparam logic [OPCODE_W-1:0] OP_MAC   = OPCODE_W'(20);
`endif

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADR   = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_EXEC_I    = 4'd10,
        S_IMM_WB    = 4'd11,
        S_JUMP      = 4'd12,
        S_MAC_ADD   = 4'd13,
        S_LINK_WB   = 4'd14,
        S_TRAP      = 4'd15
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             in_mem_state;
    logic             mem_timeout;
    logic [3:0]       alu_op;

    logic             op_is_branch;
    logic             op_is_imm;
    logic             op_is_mac;

    always_comb begin
        op_is_branch = (bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE) ||
                       (bus.opcode == OP_BGT) || (bus.opcode == OP_BGE) ||
                       (bus.opcode == OP_BLT) || (bus.opcode == OP_BLE);
        op_is_imm    = (bus.opcode == OP_ADDI) || (bus.opcode == OP_ANDI) ||
                       (bus.opcode == OP_ORI);
`ifdef MULTICYCLE_MAC_EN
        op_is_mac    = (bus.opcode == OP_MAC);
`else
        op_is_mac    = 1'b0;
`endif
    end

    // Wait counter only runs while a memory-facing state is stalled by mem_ready.
    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                          (state_q == S_MEM_WRITE);
    assign mem_timeout  = in_mem_state && !bus.mem_ready && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        wait_cnt_d = '0;
        if (in_mem_state && !bus.mem_ready && !mem_timeout) begin
            wait_cnt_d = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_RESET;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RESET:     state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready)     state_d = S_DECODE;
                else if (mem_timeout)  state_d = S_TRAP;
            end
            S_DECODE: begin
                if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW))      state_d = S_MEM_ADR;
                else if ((bus.opcode == OP_RTYPE) || op_is_mac)          state_d = S_EXEC_R;
                else if (op_is_branch)                                   state_d = S_BRANCH;
                else if (op_is_imm)                                      state_d = S_EXEC_I;
                else if ((bus.opcode == OP_J) || (bus.opcode == OP_JAL)) state_d = S_JUMP;
                else                                                     state_d = S_TRAP;
            end
            S_MEM_ADR: begin
                if (bus.opcode == OP_LW)      state_d = S_MEM_READ;
                else if (bus.opcode == OP_SW) state_d = S_MEM_WRITE;
                else                          state_d = S_TRAP;
            end
            S_MEM_READ: begin
                if (bus.mem_ready)     state_d = S_MEM_WB;
                else if (mem_timeout)  state_d = S_TRAP;
            end
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: begin
                if (bus.mem_ready)     state_d = S_FETCH;
                else if (mem_timeout)  state_d = S_TRAP;
            end
            S_EXEC_R:    state_d = op_is_mac ? S_MAC_ADD : S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_EXEC_I:    state_d = S_IMM_WB;
            S_IMM_WB:    state_d = S_FETCH;
            S_JUMP:      state_d = (bus.opcode == OP_JAL) ? S_LINK_WB : S_FETCH;
`ifdef MULTICYCLE_MAC_EN
            S_MAC_ADD:   state_d = S_ALU_WB;
`else
            S_MAC_ADD:   state_d = S_FETCH;
`endif
            S_LINK_WB:   state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
    end

    always_comb begin
        bus.memToReg       = 1'b0;
        bus.memWrite       = 1'b0;
        bus.memRead        = 1'b0;
        bus.branch         = 1'b0;
        bus.regDst         = 1'b0;
        bus.regWrite       = 1'b0;
        bus.jmp            = 1'b0;
        bus.IorD           = 1'b0;
        bus.IRWrite        = 1'b0;
        bus.pcWrite        = 1'b0;
        bus.MACsrcBsel     = 1'b0;
        bus.link           = 1'b0;
        bus.trap           = 1'b0;
        bus.ALUSrcAControl = 2'b00;
        bus.ALUSrcBControl = 2'b11;
        bus.pcSrc          = 2'b00;
        alu_op             = 4'b0001;
        unique case (state_q)
            S_RESET: begin
                bus.ALUSrcBControl = 2'b00;
                alu_op             = 4'b0000;
            end
            S_FETCH: begin
                bus.memRead        = 1'b1;
                bus.ALUSrcBControl = 2'b01;
                bus.IRWrite        = bus.mem_ready;
                bus.pcWrite        = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ALUSrcAControl = 2'b00;
                bus.ALUSrcBControl = 2'b11;
            end
            S_MEM_ADR: begin
                bus.ALUSrcAControl = 2'b01;
                bus.ALUSrcBControl = 2'b10;
                alu_op             = 4'b0001;
            end
            S_MEM_READ: begin
                bus.memRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_MEM_WB: begin
                bus.memToReg = 1'b1;
                bus.regWrite = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.memWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            S_EXEC_R: begin
                bus.ALUSrcAControl = 2'b01;
                bus.ALUSrcBControl = 2'b00;
                alu_op             = op_is_mac ? 4'b1010 : 4'b0000;
            end
            S_ALU_WB: begin
                bus.regDst   = 1'b1;
                bus.regWrite = 1'b1;
            end
            S_BRANCH: begin
                bus.branch         = 1'b1;
                bus.ALUSrcAControl = 2'b01;
                bus.ALUSrcBControl = 2'b00;
                bus.pcSrc          = 2'b01;
                bus.pcWrite        = bus.cond_true;
                if (bus.opcode == OP_BEQ)      alu_op = 4'b0100;
                else if (bus.opcode == OP_BNE) alu_op = 4'b0101;
                else if (bus.opcode == OP_BGT) alu_op = 4'b0110;
                else if (bus.opcode == OP_BGE) alu_op = 4'b0111;
                else if (bus.opcode == OP_BLT) alu_op = 4'b1000;
                else if (bus.opcode == OP_BLE) alu_op = 4'b1001;
            end
            S_EXEC_I: begin
                bus.ALUSrcAControl = 2'b01;
                bus.ALUSrcBControl = 2'b10;
                if (bus.opcode == OP_ANDI)     alu_op = 4'b0010;
                else if (bus.opcode == OP_ORI) alu_op = 4'b0011;
            end
            S_IMM_WB: begin
                bus.regWrite = 1'b1;
            end
            S_JUMP: begin
                bus.jmp     = 1'b1;
                bus.pcSrc   = 2'b10;
                bus.pcWrite = 1'b1;
            end
            S_MAC_ADD: begin
`ifdef MULTICYCLE_MAC_EN
                bus.ALUSrcAControl = 2'b11;
                bus.MACsrcBsel     = 1'b1;
                alu_op             = 4'b0001;
`endif
            end
            S_LINK_WB: begin
                bus.link     = 1'b1;
                bus.regWrite = 1'b1;
            end
            S_TRAP: begin
                bus.trap = 1'b1;
            end
            default: begin
                bus.trap = 1'b1;
            end
        endcase
    end

    assign bus.ALUOp = ALUOP_W'(alu_op);
    assign bus.state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl_fsm
//  Brief    : Scoreboard bench for multicycle_ctrl_fsm: instruction-level
//             reference model pushes expected outputs, a monitor compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

    localparam int MAXW = 15;

    localparam logic [3:0] S_RESET = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
        S_MEM_ADR = 4'd3, S_MEM_READ = 4'd4, S_MEM_WB = 4'd5, S_MEM_WRITE = 4'd6,
        S_EXEC_R = 4'd7, S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_EXEC_I = 4'd10,
        S_IMM_WB = 4'd11, S_JUMP = 4'd12, S_MAC_ADD = 4'd13, S_LINK_WB = 4'd14,
        S_TRAP = 4'd15;

    localparam logic [5:0] RTYPE = 6'd0, J = 6'd2, JAL = 6'd3, BEQ = 6'd4, BNE = 6'd5,
        ADDI = 6'd8, ANDI = 6'd12, ORI = 6'd13, BGT = 6'd14, BGE = 6'd17, BLT = 6'd18,
        BLE = 6'd19, LW = 6'd35, SW = 6'd43, MAC = 6'd20;

`ifdef MULTICYCLE_MAC_EN
    localparam bit MAC_EN = 1'b1;
`else
    localparam bit MAC_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] st;
        logic       memToReg, memWrite, memRead, branch, regDst, regWrite, jmp;
        logic       IorD, IRWrite, pcWrite, MACsrcBsel, link, trap;
        logic [5:0] aluop;
        logic [1:0] srcA, srcB, pcSrc;
    } outs_t;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;
    outs_t expq[$];

    multicycle_ctrl_fsm_if #(.OPCODE_W(6), .ALUOP_W(6)) bus ();

    multicycle_ctrl_fsm #(.OPCODE_W(6), .ALUOP_W(6), .MAX_MEM_WAIT(MAXW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit is_branch(input logic [5:0] op);
        return op inside {BEQ, BNE, BGT, BGE, BLT, BLE};
    endfunction

    // Expected strobes for one cycle, written straight from the state/opcode table.
    function automatic outs_t model(input logic [3:0] st, input logic [5:0] op,
                                    input logic mr, input logic ct);
        outs_t o;
        o = '0;
        o.st = st;
        if (st == S_RESET) return o;
        o.aluop = 6'd1;
        o.srcB  = 2'b11;
        case (st)
            S_FETCH:     begin o.memRead = 1; o.srcB = 2'b01; o.IRWrite = mr; o.pcWrite = mr; end
            S_MEM_ADR:   begin o.srcA = 2'b01; o.srcB = 2'b10; end
            S_MEM_READ:  begin o.memRead = 1; o.IorD = 1; end
            S_MEM_WB:    begin o.memToReg = 1; o.regWrite = 1; end
            S_MEM_WRITE: begin o.memWrite = 1; o.IorD = 1; end
            S_EXEC_R:    begin o.srcA = 2'b01; o.srcB = 2'b00;
                               o.aluop = (op == MAC && MAC_EN) ? 6'd10 : 6'd0; end
            S_ALU_WB:    begin o.regDst = 1; o.regWrite = 1; end
            S_BRANCH: begin
                o.branch = 1; o.srcA = 2'b01; o.srcB = 2'b00; o.pcSrc = 2'b01; o.pcWrite = ct;
                case (op)
                    BEQ: o.aluop = 6'd4;  BNE: o.aluop = 6'd5;  BGT: o.aluop = 6'd6;
                    BGE: o.aluop = 6'd7;  BLT: o.aluop = 6'd8;  BLE: o.aluop = 6'd9;
                    default: o.aluop = 6'd1;
                endcase
            end
            S_EXEC_I: begin
                o.srcA = 2'b01; o.srcB = 2'b10;
                o.aluop = (op == ANDI) ? 6'd2 : (op == ORI) ? 6'd3 : 6'd1;
            end
            S_IMM_WB:    o.regWrite = 1;
            S_JUMP:      begin o.jmp = 1; o.pcSrc = 2'b10; o.pcWrite = 1; end
            S_MAC_ADD:   if (MAC_EN) begin o.srcA = 2'b11; o.MACsrcBsel = 1; end
            S_LINK_WB:   begin o.link = 1; o.regWrite = 1; end
            S_TRAP:      o.trap = 1;
            default:     ;
        endcase
        return o;
    endfunction

    task automatic step(input logic [3:0] st, input logic mr, input logic ct, input logic rs);
        bus.mem_ready = mr;
        bus.cond_true = ct;
        reset         = rs;
        expq.push_back(model(st, bus.opcode, mr, ct));
        @(posedge clock);
        #1;
    endtask

    task automatic rstep(input logic [3:0] st);
        step(st, 1'($urandom), 1'($urandom), 1'b0);
    endtask

    // Memory-facing state stalled for 'waits' cycles; traps once MAXW+1 stalls are seen.
    task automatic wait_loop(input logic [3:0] st, input int waits, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= MAXW; i++) begin
            logic mr;
            mr = (i >= waits);
            step(st, mr, 1'($urandom), 1'b0);
            if (mr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic recover_trap();
        int n;
        n = $urandom_range(1, 3);
        repeat (n) rstep(S_TRAP);
        step(S_TRAP, 1'($urandom), 1'($urandom), 1'b1);
        rstep(S_RESET);
    endtask

    task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait,
                             input logic ct);
        bit ok;
        bus.opcode = op;
        wait_loop(S_FETCH, fwait, ok);
        if (!ok) begin recover_trap(); return; end
        rstep(S_DECODE);
        if (op == LW || op == SW) begin
            rstep(S_MEM_ADR);
            wait_loop((op == LW) ? S_MEM_READ : S_MEM_WRITE, mwait, ok);
            if (!ok) begin recover_trap(); return; end
            if (op == LW) rstep(S_MEM_WB);
        end else if (op == RTYPE || (op == MAC && MAC_EN)) begin
            rstep(S_EXEC_R);
            if (op == MAC) rstep(S_MAC_ADD);
            rstep(S_ALU_WB);
        end else if (is_branch(op)) begin
            step(S_BRANCH, 1'($urandom), ct, 1'b0);
        end else if (op inside {ADDI, ANDI, ORI}) begin
            rstep(S_EXEC_I);
            rstep(S_IMM_WB);
        end else if (op == J || op == JAL) begin
            rstep(S_JUMP);
            if (op == JAL) rstep(S_LINK_WB);
        end else begin
            recover_trap();
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clock) begin
        if (expq.size() > 0) begin
            outs_t e, a;
            e = expq.pop_front();
            a.st = bus.state;
            a.memToReg = bus.memToReg;   a.memWrite = bus.memWrite; a.memRead = bus.memRead;
            a.branch = bus.branch;       a.regDst = bus.regDst;     a.regWrite = bus.regWrite;
            a.jmp = bus.jmp;             a.IorD = bus.IorD;         a.IRWrite = bus.IRWrite;
            a.pcWrite = bus.pcWrite;     a.MACsrcBsel = bus.MACsrcBsel;
            a.link = bus.link;           a.trap = bus.trap;
            a.aluop = bus.ALUOp;         a.srcA = bus.ALUSrcAControl;
            a.srcB = bus.ALUSrcBControl; a.pcSrc = bus.pcSrc;
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs_in_state_%0d t=%0t actual=%h required=%h", e.st, $time, a, e);
            end
        end
    end

    localparam logic [5:0] OPS [15] = '{RTYPE, J, JAL, BEQ, BNE, ADDI, ANDI, ORI,
                                        BGT, BGE, BLT, BLE, LW, SW, MAC};

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 9);
        return (r < 8) ? $urandom_range(0, 2) : $urandom_range(MAXW - 2, MAXW + 1);
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.opcode  = 6'd0;
        bus.mem_ready = 1'b0;
        bus.cond_true = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        step(S_RESET, 1'b1, 1'b1, 1'b1);
        rstep(S_RESET);

        run_instr(ADDI, 0, 0, 1'b0);
        run_instr(LW, 0, 3, 1'b0);
        run_instr(BNE, 0, 0, 1'b0);
        run_instr(BNE, 0, 0, 1'b1);
        run_instr(JAL, 0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(ADDI, MAXW + 1, 0, 1'b0);
        run_instr(ANDI, MAXW, 0, 1'b0);
        run_instr(MAC, 1, 0, 1'b0);
        run_instr(SW, 0, MAXW + 1, 1'b0);
        run_instr(LW, 0, MAXW, 1'b0);

        // Reset in the middle of a stalled read must abandon the access.
        bus.opcode = LW;
        rstep(S_FETCH);
        rstep(S_DECODE);
        rstep(S_MEM_ADR);
        repeat (5) step(S_MEM_READ, 1'b0, 1'($urandom), 1'b0);
        step(S_MEM_READ, 1'b0, 1'($urandom), 1'b1);
        rstep(S_RESET);
        run_instr(ORI, MAXW, 0, 1'b1);

        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 14)];
            run_instr(op, pick_wait(), pick_wait(), 1'($urandom));
        end

        @(negedge clock);
        #1;
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain actual=%0d required=0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
